// File: rtl/alu_op_sequencer_pkg.sv
// Shared encodings for the ALU op sequencer: funct fields, ALU op codes, result-select codes, FSM states.
package alu_op_sequencer_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_SLT   = 6'd42;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [1:0] MUX_ALU = 2'b00;
  localparam logic [1:0] MUX_HI  = 2'b01;
  localparam logic [1:0] MUX_LO  = 2'b10;
  localparam logic [1:0] MUX_SHT = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  typedef struct packed {
    logic [2:0] operation;
    logic [1:0] mux_sel;
    logic       sht_en;
    logic       illegal;
    logic       is_mul;
    logic       is_div;
    logic       is_mf;
  } dec_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// EX-stage control bundle between the pipeline (master) and the op sequencer (slave).
interface alu_op_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             valid_in;
  logic [1:0]       ALUop;
  logic [5:0]       funct;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [2:0]       operation;
  logic [1:0]       mux_sel;
  logic             sht_en;
  logic             illegal;
  logic             stall;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output valid_in, ALUop, funct, src_a, src_b,
    input  operation, mux_sel, sht_en, illegal, stall, busy, hi, lo
  );

  modport slave (
    input  valid_in, ALUop, funct, src_a, src_b,
    output operation, mux_sel, sht_en, illegal, stall, busy, hi, lo
  );
endinterface

// File: rtl/alu_op_iter.sv
// Counter-driven iterative datapath: unsigned shift-add multiply, plus restoring divide when
// ALU_OP_SEQ_DIVU_EN is defined. Result lives in prod_q as {hi, lo}.
module alu_op_iter
  import alu_op_sequencer_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int STEP_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
`ifdef ALU_OP_SEQ_DIVU_EN
  input  logic             div_i,
`endif
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W     = $clog2(WIDTH) + 1;
  localparam int MUL_STEPS = WIDTH / STEP_BITS;

  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [2*WIDTH-1:0]         prod_q, prod_d;
  logic [WIDTH-1:0]           opnd_q, opnd_d;
  logic [WIDTH+STEP_BITS-1:0] partial, msum;
  logic [2*WIDTH-1:0]         mul_next;

  // Multiplier sits in the low half and is consumed from the bottom as the partial sum shifts in.
  always_comb begin
    partial = '0;
    for (int i = 0; i < STEP_BITS; i++) begin
      if (prod_q[i]) partial = partial + ({{STEP_BITS{1'b0}}, opnd_q} << i);
    end
    msum     = {{STEP_BITS{1'b0}}, prod_q[2*WIDTH-1:WIDTH]} + partial;
    mul_next = {msum, prod_q[WIDTH-1:STEP_BITS]};
  end

`ifdef ALU_OP_SEQ_DIVU_EN
  logic               div_q, div_d;
  logic [WIDTH:0]     rem_sh, diff;
  logic [2*WIDTH-1:0] div_next;

  // Remainder in the high half, dividend/quotient in the low half; a zero divisor naturally
  // yields quotient all ones and remainder equal to the dividend.
  always_comb begin
    rem_sh = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, opnd_q};
    if (!diff[WIDTH]) div_next = {diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
    else              div_next = {rem_sh[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
  end
`endif

  always_comb begin
    cnt_d  = cnt_q;
    prod_d = prod_q;
    opnd_d = opnd_q;
`ifdef ALU_OP_SEQ_DIVU_EN
    div_d  = div_q;
    if (load_i) begin
      div_d = div_i;
      if (div_i) begin
        prod_d = {{WIDTH{1'b0}}, a_i};
        opnd_d = b_i;
        cnt_d  = CNT_W'(WIDTH);
      end else begin
        prod_d = {{WIDTH{1'b0}}, b_i};
        opnd_d = a_i;
        cnt_d  = CNT_W'(MUL_STEPS);
      end
    end else if (step_i && cnt_q != '0) begin
      cnt_d  = cnt_q - CNT_W'(1);
      prod_d = div_q ? div_next : mul_next;
    end
`else
    if (load_i) begin
      prod_d = {{WIDTH{1'b0}}, b_i};
      opnd_d = a_i;
      cnt_d  = CNT_W'(MUL_STEPS);
    end else if (step_i && cnt_q != '0) begin
      cnt_d  = cnt_q - CNT_W'(1);
      prod_d = mul_next;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      prod_q <= '0;
      opnd_q <= '0;
`ifdef ALU_OP_SEQ_DIVU_EN
      div_q  <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      prod_q <= prod_d;
      opnd_q <= opnd_d;
`ifdef ALU_OP_SEQ_DIVU_EN
      div_q  <= div_d;
`endif
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));
  assign hi_o   = prod_q[2*WIDTH-1:WIDTH];
  assign lo_o   = prod_q[WIDTH-1:0];

endmodule

// File: rtl/alu_op_sequencer.sv
// EX-stage ALU control decode plus HI/LO multi-cycle sequencer; DIVU is built in with ALU_OP_SEQ_DIVU_EN.
// state | meaning:  IDLE | no multi-cycle op;  RUN | one iteration per cycle;  DONE | write HI/LO, one cycle
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int STEP_BITS = 1
) (
  input logic               clk,
  input logic               rst,
  alu_op_sequencer_if.slave bus
);

  dec_t             dec;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] iter_hi, iter_lo;
  logic             iter_last, busy, stall, start;

  always_comb begin
    dec           = '0;
    dec.operation = OP_ADD;
    dec.mux_sel   = MUX_ALU;
    case (bus.ALUop)
      ALUOP_ADD: dec.operation = OP_ADD;
      ALUOP_SUB: dec.operation = OP_SUB;
      ALUOP_RTYPE: begin
        case (bus.funct)
          F_AND:   dec.operation = OP_AND;
          F_OR:    dec.operation = OP_OR;
          F_ADD:   dec.operation = OP_ADD;
          F_SUB:   dec.operation = OP_SUB;
          F_SLT:   dec.operation = OP_SLT;
          F_SLL: begin
            dec.sht_en  = 1'b1;
            dec.mux_sel = MUX_SHT;
          end
          F_MFHI: begin
            dec.mux_sel = MUX_HI;
            dec.is_mf   = 1'b1;
          end
          F_MFLO: begin
            dec.mux_sel = MUX_LO;
            dec.is_mf   = 1'b1;
          end
          F_MULTU: dec.is_mul = 1'b1;
`ifdef ALU_OP_SEQ_DIVU_EN
          F_DIVU:  dec.is_div = 1'b1;
`endif
          default: dec.illegal = bus.valid_in;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  assign busy  = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign stall = busy && bus.valid_in && (dec.is_mul || dec.is_div || dec.is_mf);
  assign start = (state_q == ST_IDLE) && bus.valid_in && (dec.is_mul || dec.is_div) && !stall;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (iter_last) state_d = ST_DONE;
      ST_DONE: begin
        hi_d    = iter_hi;
        lo_d    = iter_lo;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  alu_op_iter #(
    .WIDTH     (WIDTH),
    .STEP_BITS (STEP_BITS)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .load_i (start),
    .step_i (state_q == ST_RUN),
`ifdef ALU_OP_SEQ_DIVU_EN
    .div_i  (dec.is_div),
`endif
    .a_i    (bus.src_a),
    .b_i    (bus.src_b),
    .last_o (iter_last),
    .hi_o   (iter_hi),
    .lo_o   (iter_lo)
  );

  assign bus.operation = dec.operation;
  assign bus.mux_sel   = dec.mux_sel;
  assign bus.sht_en    = dec.sht_en;
  assign bus.illegal   = dec.illegal;
  assign bus.stall     = stall;
  assign bus.busy      = busy;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer (WIDTH=32, STEP_BITS=1); DIVU cases follow ALU_OP_SEQ_DIVU_EN.
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;

  alu_op_sequencer_if #(.WIDTH(32)) bus ();

  alu_op_sequencer #(.WIDTH(32), .STEP_BITS(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    bus.valid_in = v;
    bus.ALUop    = op;
    bus.funct    = f;
    bus.src_a    = a;
    bus.src_b    = b;
  endtask

  task automatic dec_case(input string tag, input logic [1:0] op, input logic [5:0] f,
                          input logic [2:0] e_op, input logic [1:0] e_mux,
                          input logic e_sht, input logic e_ill);
    tick();
    drive(1'b1, op, f, 32'h0, 32'h0);
    @(negedge clk);
    chk({tag, "_op"},    64'(bus.operation), 64'(e_op));
    chk({tag, "_mux"},   64'(bus.mux_sel),   64'(e_mux));
    chk({tag, "_sht"},   64'(bus.sht_en),    64'(e_sht));
    chk({tag, "_ill"},   64'(bus.illegal),   64'(e_ill));
    chk({tag, "_stall"}, 64'(bus.stall),     64'd0);
  endtask

  // Accept in cycle N, expect busy in N+lat-1 and hi/lo with busy low in N+lat.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int lat,
                        input logic [31:0] e_hi, input logic [31:0] e_lo);
    tick();
    drive(1'b1, ALUOP_RTYPE, f, a, b);
    @(negedge clk);
    chk({tag, "_accept_stall"}, 64'(bus.stall), 64'd0);
    tick();
    drive(1'b0, ALUOP_ADD, 6'd0, 32'h0, 32'h0);
    repeat (lat - 2) tick();
    @(negedge clk);
    chk({tag, "_busy_done"}, 64'(bus.busy), 64'd1);
    tick();
    @(negedge clk);
    chk({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
    chk({tag, "_hi"}, 64'(bus.hi), 64'(e_hi));
    chk({tag, "_lo"}, 64'(bus.lo), 64'(e_lo));
  endtask

  initial begin
    int n_st;
    drive(1'b0, ALUOP_ADD, 6'd0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  64'(bus.busy),      64'd0);
    chk("rst_stall", 64'(bus.stall),     64'd0);
    chk("rst_hi",    64'(bus.hi),        64'd0);
    chk("rst_lo",    64'(bus.lo),        64'd0);
    chk("rst_op",    64'(bus.operation), 64'(3'b010));
    tick();
    rst = 1'b0;

    dec_case("add_cls", 2'b00, 6'd0,  3'b010, 2'b00, 1'b0, 1'b0);
    dec_case("sub_cls", 2'b01, 6'd0,  3'b110, 2'b00, 1'b0, 1'b0);
    dec_case("and",     2'b10, 6'd36, 3'b000, 2'b00, 1'b0, 1'b0);
    dec_case("or",      2'b10, 6'd37, 3'b001, 2'b00, 1'b0, 1'b0);
    dec_case("add",     2'b10, 6'd32, 3'b010, 2'b00, 1'b0, 1'b0);
    dec_case("sub",     2'b10, 6'd34, 3'b110, 2'b00, 1'b0, 1'b0);
    dec_case("slt",     2'b10, 6'd42, 3'b111, 2'b00, 1'b0, 1'b0);
    dec_case("sll",     2'b10, 6'd0,  3'b010, 2'b11, 1'b1, 1'b0);
    dec_case("mfhi",    2'b10, 6'd16, 3'b010, 2'b01, 1'b0, 1'b0);
    dec_case("mflo",    2'b10, 6'd18, 3'b010, 2'b10, 1'b0, 1'b0);
    dec_case("bad_fn",  2'b10, 6'd5,  3'b010, 2'b00, 1'b0, 1'b1);
    dec_case("aluop11", 2'b11, 6'd32, 3'b010, 2'b00, 1'b0, 1'b1);
    @(negedge clk);
    chk("dec_no_busy", 64'(bus.busy), 64'd0);

    // 0xFFFFFFFF * 2 with an ADD issued during RUN.
    tick();
    drive(1'b1, ALUOP_RTYPE, F_MULTU, 32'hFFFF_FFFF, 32'h2);
    @(negedge clk);
    chk("m1_accept_stall", 64'(bus.stall), 64'd0);
    chk("m1_accept_busy",  64'(bus.busy),  64'd0);
    tick();
    drive(1'b1, ALUOP_RTYPE, F_ADD, 32'h5, 32'h6);
    @(negedge clk);
    chk("m1_run_busy",   64'(bus.busy),      64'd1);
    chk("m1_add_stall",  64'(bus.stall),     64'd0);
    chk("m1_add_op",     64'(bus.operation), 64'(3'b010));
    tick();
    drive(1'b0, ALUOP_ADD, 6'd0, 32'h0, 32'h0);
    repeat (31) tick();
    @(negedge clk);
    chk("m1_done_busy", 64'(bus.busy), 64'd1);
    chk("m1_done_lo_old", 64'(bus.lo), 64'd0);
    tick();
    @(negedge clk);
    chk("m1_hi",   64'(bus.hi),   64'h1);
    chk("m1_lo",   64'(bus.lo),   64'hFFFF_FFFE);
    chk("m1_busy", 64'(bus.busy), 64'd0);

    // 0xFFFFFFFF^2 with MFLO three cycles after acceptance.
    tick();
    drive(1'b1, ALUOP_RTYPE, F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    drive(1'b0, ALUOP_ADD, 6'd0, 32'h0, 32'h0);
    tick();
    tick();
    drive(1'b1, ALUOP_RTYPE, F_MFLO, 32'h0, 32'h0);
    n_st = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!bus.stall) break;
      n_st++;
      tick();
    end
    chk("m2_stall_cycles", 64'(n_st), 64'd31);
    chk("m2_mux",  64'(bus.mux_sel), 64'(2'b10));
    chk("m2_lo",   64'(bus.lo),      64'h1);
    chk("m2_hi",   64'(bus.hi),      64'hFFFF_FFFE);
    tick();
    drive(1'b0, ALUOP_ADD, 6'd0, 32'h0, 32'h0);

    // 0x10000^2, a MULTU queued in DONE, then reset in the middle of that second run.
    tick();
    drive(1'b1, ALUOP_RTYPE, F_MULTU, 32'h0001_0000, 32'h0001_0000);
    tick();
    drive(1'b0, ALUOP_ADD, 6'd0, 32'h0, 32'h0);
    repeat (32) tick();
    drive(1'b1, ALUOP_RTYPE, F_MULTU, 32'h10, 32'h10);
    @(negedge clk);
    chk("m3_done_stall", 64'(bus.stall), 64'd1);
    chk("m3_done_busy",  64'(bus.busy),  64'd1);
    tick();
    @(negedge clk);
    chk("m3_idle_stall", 64'(bus.stall), 64'd0);
    chk("m3_hi",         64'(bus.hi),    64'h1);
    chk("m3_lo",         64'(bus.lo),    64'h0);
    tick();
    drive(1'b0, ALUOP_ADD, 6'd0, 32'h0, 32'h0);
    @(negedge clk);
    chk("m4_accepted_busy", 64'(bus.busy), 64'd1);
    repeat (3) tick();
    rst = 1'b1;
    @(negedge clk);
    chk("m4_rst_pending_busy", 64'(bus.busy), 64'd1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("m4_rst_busy",  64'(bus.busy),  64'd0);
    chk("m4_rst_stall", 64'(bus.stall), 64'd0);
    chk("m4_rst_hi",    64'(bus.hi),    64'd0);
    repeat (40) tick();
    @(negedge clk);
    chk("m4_abort_hi", 64'(bus.hi), 64'd0);
    chk("m4_abort_lo", 64'(bus.lo), 64'd0);

    run_op("m5", F_MULTU, 32'd3, 32'd5, 34, 32'h0, 32'd15);

`ifdef ALU_OP_SEQ_DIVU_EN
    run_op("d1", F_DIVU, 32'd7,   32'd0, 34, 32'd7, 32'hFFFF_FFFF);
    run_op("d2", F_DIVU, 32'd100, 32'd7, 34, 32'd2, 32'd14);
`else
    tick();
    drive(1'b1, ALUOP_RTYPE, F_DIVU, 32'd7, 32'd0);
    @(negedge clk);
    chk("divu_off_ill", 64'(bus.illegal), 64'd1);
    tick();
    drive(1'b0, ALUOP_ADD, 6'd0, 32'h0, 32'h0);
    @(negedge clk);
    chk("divu_off_busy", 64'(bus.busy), 64'd0);
    chk("divu_off_lo",   64'(bus.lo),   64'd15);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
